// File: rtl/gpio_pio_pkg.sv
// Shared constants for the bidirectional GPIO block: register word addresses,
// capture-edge encodings and the startup mask count.
package gpio_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Cycles after reset before the sync chain holds only real pin samples.
  localparam logic [1:0] STARTUP_DONE = 2'd3;

endpackage

// File: rtl/gpio_edge_sync.sv
// Two-flop pin synchronizer with a one-cycle history register and per-bit
// edge pulses; pulses are suppressed until the chain is free of reset zeros.
module gpio_edge_sync
  import gpio_pio_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edges
);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_prev;
  logic [WIDTH-1:0] raw_edges;
  logic [1:0]       startup_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta   <= '0;
      sync_in     <= '0;
      sync_prev   <= '0;
      startup_cnt <= '0;
    end else begin
      sync_meta <= pins;
      sync_in   <= sync_meta;
      sync_prev <= sync_in;
      if (startup_cnt != STARTUP_DONE) begin
        startup_cnt <= startup_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    raw_edges = '0;
    case (EDGE_TYPE)
      EDGE_FALLING: raw_edges = ~sync_in & sync_prev;
      EDGE_ANY:     raw_edges = sync_in ^ sync_prev;
      default:      raw_edges = sync_in & ~sync_prev;
    endcase
  end

  // Hides the 0 -> pin transition produced by the chain leaving reset.
  assign edges = (startup_cnt == STARTUP_DONE) ? raw_edges : '0;

endmodule

// File: rtl/gpio_bidir_pio.sv
// Memory-mapped bidirectional GPIO: data/direction registers, set/clear
// aliases, write-1-to-clear edge capture and a masked level interrupt.
module gpio_bidir_pio
  import gpio_pio_pkg::*;
#(
  parameter int          WIDTH     = 2,
  parameter int          EDGE_TYPE = EDGE_RISING,
  parameter logic [31:0] RESET_OUT = 32'd0,
  parameter logic [31:0] RESET_DIR = 32'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  inout  wire  [WIDTH-1:0] bidir_port,
  output logic             irq
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wr_upper;

  assign wr_en           = chipselect & ~write_n;
  assign wr_bits         = writedata[WIDTH-1:0];
  assign unused_wr_upper = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = data_dir[i] ? data_out[i] : 1'bz;
  end

  gpio_edge_sync #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pins    (bidir_port),
    .sync_in (sync_in),
    .edges   (edges)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT[WIDTH-1:0];
      data_dir <= RESET_DIR[WIDTH-1:0];
      irq_mask <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:    data_out <= wr_bits;
        ADDR_DIR:     data_dir <= wr_bits;
        ADDR_IRQMASK: irq_mask <= wr_bits;
        ADDR_OUTSET:  data_out <= data_out | wr_bits;
        ADDR_OUTCLR:  data_out <= data_out & ~wr_bits;
        default:      ;
      endcase
    end
  end

  assign cap_clr = (wr_en && (address == ADDR_EDGECAP)) ? wr_bits : '0;

  // A new edge is ORed in after the clear, so it survives a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | edges;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_in;
      ADDR_DIR:     rd_mux[WIDTH-1:0] = data_dir;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule
